bcd_display_scanner: RTL and testbench
======================================

# bcd_display_scanner

Downstream consumer of the 8-bit binary-to-BCD converter.
- Accepts a 12-bit, 3-digit packed BCD value through a valid/ready handshake.
- Double-buffers the value so the display never tears mid-frame.
- Time-multiplexes the three digits onto one shared 7-segment bus with per-digit anode enables and optional leading-zero blanking.
- Sits between the converter output and the board's 3-digit common-anode display.

## Interface
Parameters:
- REFRESH_DIV, 50000, clk cycles each digit stays lit (>=2).
- SEG_ACTIVE_LOW, 1, invert seg outputs when 1.
- AN_ACTIVE_LOW, 1, invert an outputs when 1.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- bcd_in  in  12  {hundreds, tens, ones} BCD nibbles.
- in_valid  in  1  bcd_in is valid.
- in_ready  out  1  block can accept; a transfer occurs when in_valid && in_ready at a rising edge.
- blank_lz  in  1  enable leading-zero blanking; sampled live.
- seg  out  7  {g,f,e,d,c,b,a}, registered.
- an  out  3  one-hot digit enable; an[0] is the ones digit; registered.

## Operation
- **Prescaler:** counts 0..REFRESH_DIV-1 and wraps. `tick` is asserted when the count equals REFRESH_DIV-1.
- **Digit index:** sequence 0→1→2→0, advancing on `tick`. A frame boundary is `tick` while the index is 2.
- **Pending buffer:** register plus a `pend` flag. `in_ready = ~pend`. An accepted transfer loads the buffer and sets `pend`.
- **Display register:** at a frame boundary with `pend` set, the display register is loaded from the pending buffer and `pend` clears. `in_ready` rises the following cycle.
- **Simultaneous commit and input:** at a frame boundary with `pend` set, `in_ready` is 0, so no accept can occur that cycle. No data is lost or duplicated.
- **Decode:** values 0-9 use the standard glyphs. Nibbles 0xA-0xF display a dash (g only, 7'h40).
- **Blanking (blank_lz=1):**
  - Hundreds digit is blank when it is 0.
  - Tens digit is blank when hundreds and tens are both 0.
  - Ones digit is never blanked.
  - A blank digit has all segments off, but its anode still scans.
- **Outputs:** `an` and `seg` are registered from the current index and display register. Polarity inversion is applied last.

## Timing
- **Reset (rst_n low at a clk edge):**
  - Prescaler = 0, index = 0, `pend` = 0, pending buffer and display register = 12'h000.
  - `seg` is all off and `an` is all off (physical levels follow the polarity parameters).
  - `in_ready` is 1 while `pend` = 0; an in_valid presented during reset is ignored (reset has priority).
- **After release:** the first registered output (an = 3'b001, ones glyph) appears at the 1st edge after rst_n goes high.
- **Digit dwell:** an/seg change exactly every REFRESH_DIV cycles, one cycle after `tick`. A full frame is 3*REFRESH_DIV cycles.
- **Load-to-display latency:** from accept to the new value showing on the ones digit, at least 1 cycle and at most 3*REFRESH_DIV+1 cycles (wait for the frame boundary, plus the output register).
- **Reset mid-frame:** aborts the scan and discards pending and displayed data. A held in_valid is accepted on the first edge after release.
- **Live inputs:** a blank_lz change takes effect on the next output register update; no frame alignment is applied.

## Structure
- **Package bcd_disp_pkg** holds:
  - the digit count constant (3);
  - a seg7 glyph LUT function: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, dash=40, active-high;
  - the blank constant 7'h00.
- **Sub-module bcd_to_seg7:** combinational nibble plus blank → 7-bit active-high pattern. It is instantiated once on the muxed digit.
- **Top:** prescaler, index counter, pending/display registers and output registers. Expected size is about 150 lines.

## Test plan
All scenarios use REFRESH_DIV=4 and both polarity parameters = 0 (active-high).
1. **Reset, no load, blank_lz=1:** an cycles 001→010→100 every 4 cycles; seg = 3F on an=001 and 00 on the other two digits.
2. **Accept 12'h129 mid-frame:** in_ready drops the next cycle. After the frame boundary, seg is 6F/5B/06 for an = 001/010/100, and in_ready returns to 1.
3. **Leading zeros, 12'h005:**
   - blank_lz=1 → 6D, 00, 00.
   - blank_lz=0 → 6D, 3F, 3F.
   - 12'h050 with blank_lz=1 → 3F, 6D, 00.
4. **Backpressure:** in_valid held high with 12'h111 then 12'h222 back-to-back. The second is stalled (in_ready=0) until the boundary after the first commits, and both appear in order with no drop.
5. **Invalid nibble, 12'h0A3:** seg shows 4F, 40, 00 with blank_lz=1; the dash is not blanked because the nibble is non-zero.
6. **Reset mid-frame:** pulse rst_n low during index 1 with `pend` set. Outputs go all-off, the display returns to "0", and the pending value never appears.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// rtl/bcd_disp_pkg.sv - shared constants and 7-segment glyph table for the BCD display scanner
package bcd_disp_pkg;

    localparam int NUM_DIGITS = 3;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    // Active-high {g,f,e,d,c,b,a}; non-decimal nibbles render as a dash.
    function automatic logic [6:0] seg7_glyph(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = SEG_DASH;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD nibble to active-high 7-segment pattern
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] pattern
);

    assign pattern = blank ? SEG_BLANK : seg7_glyph(digit);

endmodule

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - double-buffered 3-digit multiplexed 7-segment scanner
module bcd_display_scanner
    import bcd_disp_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] bcd_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    localparam int             CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [1:0]     IDX_LAST = 2'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          pend;
    logic [11:0]   pbuf;
    logic [11:0]   dreg;

    logic          tick;
    logic          frame_end;
    logic [3:0]    cur_digit;
    logic          cur_blank;
    logic [6:0]    cur_pattern;
    logic [2:0]    an_next;

    assign tick      = (cnt == CNT_LAST);
    assign frame_end = tick && (idx == IDX_LAST);
    assign in_ready  = ~pend;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                idx <= frame_end ? 2'd0 : idx + 2'd1;
            end
        end
    end

    // Commit only at a frame boundary; in_ready is low then, so commit and accept never collide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= 1'b0;
            pbuf <= 12'h000;
            dreg <= 12'h000;
        end else if (frame_end && pend) begin
            dreg <= pbuf;
            pend <= 1'b0;
        end else if (in_valid && !pend) begin
            pbuf <= bcd_in;
            pend <= 1'b1;
        end
    end

    always_comb begin
        cur_digit = dreg[3:0];
        cur_blank = 1'b0;
        an_next   = 3'b001;
        case (idx)
            2'd0: begin
                cur_digit = dreg[3:0];
                an_next   = 3'b001;
            end
            2'd1: begin
                cur_digit = dreg[7:4];
                cur_blank = blank_lz && (dreg[11:4] == 8'h00);
                an_next   = 3'b010;
            end
            default: begin
                cur_digit = dreg[11:8];
                cur_blank = blank_lz && (dreg[11:8] == 4'h0);
                an_next   = 3'b100;
            end
        endcase
    end

    bcd_to_seg7 u_dec (
        .digit   (cur_digit),
        .blank   (cur_blank),
        .pattern (cur_pattern)
    );

    // Reset value is "all off" at the physical polarity.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg <= {7{SEG_ACTIVE_LOW}};
            an  <= {3{AN_ACTIVE_LOW}};
        end else begin
            seg <= cur_pattern ^ {7{SEG_ACTIVE_LOW}};
            an  <= an_next ^ {3{AN_ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - self-checking bench for bcd_display_scanner
module tb_bcd_display_scanner;

    localparam int DIV   = 4;
    localparam int FRAME = 3 * DIV;
    localparam logic [6:0] GLYPHS [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] bcd_in = 12'h000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        blank_lz = 1'b1;
    logic [6:0]  seg;
    logic [2:0]  an;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bcd_display_scanner #(
        .REFRESH_DIV    (DIV),
        .SEG_ACTIVE_LOW (1'b0),
        .AN_ACTIVE_LOW  (1'b0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bcd_in   (bcd_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .blank_lz (blank_lz),
        .seg      (seg),
        .an       (an)
    );

    // Reference model: edge k after reset release shows digit (k mod FRAME)/DIV;
    // the frame's last edge is where a pending value becomes the displayed value.
    int          m_k = 0;
    logic        m_pend = 1'b0;
    logic [11:0] m_pbuf = 12'h000;
    logic [11:0] m_disp = 12'h000;
    logic [2:0]  m_an = 3'b000;
    logic [6:0]  m_seg = 7'h00;

    function automatic logic [6:0] exp_glyph(input logic [11:0] v, input int i, input logic blz);
        logic [3:0] d;
        d = 4'((v >> (4 * i)) & 12'hF);
        if (i > 0 && blz && (v >> (4 * i)) == 12'h000) return 7'h00;
        if (d > 4'd9) return 7'h40;
        return GLYPHS[d];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_k    <= 0;
            m_pend <= 1'b0;
            m_pbuf <= 12'h000;
            m_disp <= 12'h000;
            m_an   <= 3'b000;
            m_seg  <= 7'h00;
        end else begin
            m_an  <= 3'(1 << ((m_k % FRAME) / DIV));
            m_seg <= exp_glyph(m_disp, (m_k % FRAME) / DIV, blank_lz);
            if ((m_k % FRAME) == FRAME - 1 && m_pend) begin
                m_disp <= m_pbuf;
                m_pend <= 1'b0;
            end else if (in_valid && !m_pend) begin
                m_pbuf <= bcd_in;
                m_pend <= 1'b1;
            end
            m_k <= m_k + 1;
        end
    end

    // Stimulus only: present v and hold until the handshake completes.
    task automatic send(input logic [11:0] v);
        int w = 0;
        bcd_in   = v;
        in_valid = 1'b1;
        while (!in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, w);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        bcd_in   = 12'h999;
        blank_lz = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (an !== 3'b000 || seg !== 7'h00) begin
            n_bad++;
            $display("FAIL reset_outputs: an=%b seg=%h, required an=000 seg=00", an, seg);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (an !== 3'b001 || seg !== 7'h3F) begin
            n_bad++;
            $display("FAIL first_output: an=%b seg=%h, required an=001 seg=3f", an, seg);
        end
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            n_cmp++;
            if (an !== m_an || seg !== m_seg || in_ready !== !m_pend) begin
                n_bad++;
                $display("FAIL idle_scan: an=%b seg=%h rdy=%b, required an=%b seg=%h rdy=%b",
                         an, seg, in_ready, m_an, m_seg, !m_pend);
            end
        end
    endtask

    task automatic test_load_129;
        repeat (2) @(negedge clk);
        bcd_in   = 12'h129;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_drop: in_ready=%b, required 0", in_ready);
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n_cmp++;
            if (an !== m_an || seg !== m_seg || in_ready !== !m_pend) begin
                n_bad++;
                $display("FAIL load_scan: an=%b seg=%h rdy=%b, required an=%b seg=%h rdy=%b",
                         an, seg, in_ready, m_an, m_seg, !m_pend);
            end
        end
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            n_cmp++;
            if (!((an === 3'b001 && seg === 7'h6F) || (an === 3'b010 && seg === 7'h5B) ||
                  (an === 3'b100 && seg === 7'h06)) || in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL show_129: an=%b seg=%h rdy=%b, required 6f/5b/06 on 001/010/100 rdy=1",
                         an, seg, in_ready);
            end
        end
    endtask

    task automatic test_leading_zero;
        logic [11:0] vals [3] = '{12'h005, 12'h005, 12'h050};
        logic        blzs [3] = '{1'b1, 1'b0, 1'b1};
        logic [6:0]  exps [3][3] = '{'{7'h6D, 7'h00, 7'h00},
                                     '{7'h6D, 7'h3F, 7'h3F},
                                     '{7'h3F, 7'h6D, 7'h00}};
        for (int c = 0; c < 3; c++) begin
            blank_lz = blzs[c];
            send(vals[c]);
            repeat (2 * FRAME + 2) @(negedge clk);
            for (int i = 0; i < FRAME; i++) begin
                @(negedge clk);
                n_cmp++;
                if (!((an === 3'b001 && seg === exps[c][0]) || (an === 3'b010 && seg === exps[c][1]) ||
                      (an === 3'b100 && seg === exps[c][2]))) begin
                    n_bad++;
                    $display("FAIL leading_zero[%0d]: an=%b seg=%h, required %h/%h/%h on 001/010/100",
                             c, an, seg, exps[c][0], exps[c][1], exps[c][2]);
                end
            end
        end
    endtask

    task automatic test_invalid_nibble;
        blank_lz = 1'b1;
        send(12'h0A3);
        repeat (2 * FRAME + 2) @(negedge clk);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            n_cmp++;
            if (!((an === 3'b001 && seg === 7'h4F) || (an === 3'b010 && seg === 7'h40) ||
                  (an === 3'b100 && seg === 7'h00))) begin
                n_bad++;
                $display("FAIL invalid_nibble: an=%b seg=%h, required 4f/40/00 on 001/010/100", an, seg);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic seen_first = 1'b0;
        logic drop_next  = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_start_ready: in_ready=%b, required 1", in_ready);
        end
        bcd_in   = 12'h111;
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n_cmp++;
            if (an !== m_an || seg !== m_seg || in_ready !== !m_pend) begin
                n_bad++;
                $display("FAIL bp_scan: an=%b seg=%h rdy=%b, required an=%b seg=%h rdy=%b",
                         an, seg, in_ready, m_an, m_seg, !m_pend);
            end
            if (an === 3'b100 && seg === 7'h06) seen_first = 1'b1;
            if (i == 0) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL bp_stall: in_ready=%b, required 0", in_ready);
                end
                bcd_in = 12'h222;
            end else if (drop_next) begin
                in_valid  = 1'b0;
                drop_next = 1'b0;
            end else if (in_valid && in_ready) begin
                drop_next = 1'b1;
            end
        end
        n_cmp++;
        if (!seen_first || in_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_order: first_shown=%b valid_still_held=%b, required 1 and 0",
                     seen_first, in_valid);
        end
        in_valid = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            n_cmp++;
            if (seg !== 7'h5B) begin
                n_bad++;
                $display("FAIL bp_final: an=%b seg=%h, required seg=5b", an, seg);
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n_cmp++;
            if (an !== m_an || seg !== m_seg || in_ready !== !m_pend) begin
                n_bad++;
                $display("FAIL random[%0d]: an=%b seg=%h rdy=%b, required an=%b seg=%h rdy=%b",
                         i, an, seg, in_ready, m_an, m_seg, !m_pend);
            end
            in_valid = ($urandom_range(0, 2) == 0);
            bcd_in   = 12'($urandom);
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
        end
        in_valid = 1'b0;
        blank_lz = 1'b1;
    endtask

    task automatic test_reset_midframe;
        int w = 0;
        while (!((m_k % FRAME) == DIV && in_ready) && w < 40) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (!((m_k % FRAME) == DIV && in_ready)) begin
            n_bad++;
            $display("FAIL midframe_align: not aligned after %0d cycles (rdy=%b), required aligned", w, in_ready);
        end
        bcd_in   = 12'h456;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0 || an !== 3'b010) begin
            n_bad++;
            $display("FAIL pend_before_reset: rdy=%b an=%b, required rdy=0 an=010", in_ready, an);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (an !== 3'b000 || seg !== 7'h00 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_midframe: an=%b seg=%h rdy=%b, required an=000 seg=00 rdy=1", an, seg, in_ready);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            n_cmp++;
            if (an !== m_an || seg !== m_seg ||
                !((an === 3'b001 && seg === 7'h3F) || (an !== 3'b001 && seg === 7'h00))) begin
                n_bad++;
                $display("FAIL after_reset: an=%b seg=%h, required an=%b seg=%h showing 0",
                         an, seg, m_an, m_seg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_129();
        test_leading_zero();
        test_invalid_nibble();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
